// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with {HI,LO} result register.
// Single-cycle add/sub/logic/shift/rotate ops. Signed multiply and divide
// run on a shared iterative engine: shift-add multiply or restoring divide.
// Ports:
//   clk          rising-edge clock
//   clear        asynchronous active-high reset
//   start        request, accepted only while idle (busy = 0)
//   op           operation code, latched at accept
//   a, b         signed operands, latched at accept
//   z            {HI, LO} result register (2*WIDTH bits)
//   carry        add carry-out / sub no-borrow, 0 for other ops
//   busy         multiply/divide in progress
//   done         one-cycle pulse when z/carry/div_by_zero were just updated
//   div_by_zero  last completed op was a divide with b = 0
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] z,
  output logic               carry,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;
  localparam int unsigned W2  = 2 * WIDTH;
  localparam int unsigned WW  = 2 * WIDTH + 1;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SRA = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_NEG = 4'b1000;
  localparam logic [3:0] OP_PSB = 4'b1001;
  localparam logic [3:0] OP_NOT = 4'b1010;
  localparam logic [3:0] OP_SHL = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;
  localparam logic [3:0] OP_ROL = 4'b1110;
  localparam logic [3:0] OP_ROR = 4'b1111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // Registered state
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WW-1:0]    work;      // mul: {acc_hi, multiplier}; div: {rem, quotient}
  logic [WIDTH-1:0] opnd;      // mul: |a| multiplicand; div: |b| divisor
  logic             is_div;
  logic             neg_res;   // operand signs differ
  logic             sign_a;    // remainder takes the sign of a

  // Next-state values
  logic [1:0]       state_d;
  logic [CW-1:0]    cnt_d;
  logic [WW-1:0]    work_d;
  logic [WIDTH-1:0] opnd_d;
  logic             is_div_d;
  logic             neg_res_d;
  logic             sign_a_d;
  logic [W2-1:0]    z_d;
  logic             carry_d;
  logic             busy_d;
  logic             done_d;
  logic             dbz_d;

  // Operand magnitudes; |-2^(WIDTH-1)| is representable as unsigned
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  assign mag_a = a[WIDTH-1] ? WIDTH'(-a) : a;
  assign mag_b = b[WIDTH-1] ? WIDTH'(-b) : b;

  // Add / subtract with carry-out
  logic [WIDTH:0] add_full;
  logic [WIDTH:0] sub_full;
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  // Shifts saturate when the full unsigned b is >= WIDTH; rotates use b mod WIDTH
  logic             shift_big;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] shl_res;
  logic [WIDTH-1:0] shr_res;
  logic [WIDTH-1:0] sra_res;
  logic [W2-1:0]    rol_dbl;
  logic [W2-1:0]    ror_dbl;
  assign shift_big = |b[WIDTH-1:SHW];
  assign amt       = b[SHW-1:0];
  assign shl_res   = shift_big ? '0 : (a << amt);
  assign shr_res   = shift_big ? '0 : (a >> amt);
  assign sra_res   = shift_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($unsigned($signed(a) >>> amt));
  assign rol_dbl   = {a, a} << amt;
  assign ror_dbl   = {a, a} >> amt;

  // One shift-add multiply step: conditional add into the high half, then shift right
  logic [WIDTH:0]  mul_hi;
  logic [WW-1:0]   mul_next;
  assign mul_hi   = work[W2:WIDTH] + (work[0] ? {1'b0, opnd} : '0);
  assign mul_next = {1'b0, mul_hi, work[WIDTH-1:1]};

  // One restoring divide step: shift {rem, quo} left, trial-subtract divisor
  logic [WIDTH:0]  div_rem_sh;
  logic [WIDTH:0]  div_trial;
  logic [WW-1:0]   div_next;
  assign div_rem_sh = work[W2-1:WIDTH-1];
  assign div_trial  = div_rem_sh - {1'b0, opnd};
  assign div_next   = div_trial[WIDTH] ? {div_rem_sh, work[WIDTH-2:0], 1'b0}
                                       : {div_trial,  work[WIDTH-2:0], 1'b1};

  // Sign fix-up applied in the FIX state
  logic [W2-1:0]    prod;
  logic [W2-1:0]    mul_res;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;
  assign prod    = work[W2-1:0];
  assign mul_res = neg_res ? W2'(-prod) : prod;
  assign quo     = work[WIDTH-1:0];
  assign rem     = work[W2-1:WIDTH];
  assign quo_res = neg_res ? WIDTH'(-quo) : quo;
  assign rem_res = sign_a  ? WIDTH'(-rem) : rem;

  // Next-state and output logic
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    work_d    = work;
    opnd_d    = opnd;
    is_div_d  = is_div;
    neg_res_d = neg_res;
    sign_a_d  = sign_a;
    z_d       = z;
    carry_d   = carry;
    done_d    = 1'b0;
    dbz_d     = div_by_zero;

    case (state)
      S_IDLE: begin
        if (start) begin
          // Most ops complete here; mul/div override to enter ITER
          done_d  = 1'b1;
          carry_d = 1'b0;
          dbz_d   = 1'b0;
          case (op)
            OP_ADD: begin
              z_d[WIDTH-1:0] = add_full[WIDTH-1:0];
              carry_d        = add_full[WIDTH];
            end
            OP_SUB: begin
              z_d[WIDTH-1:0] = sub_full[WIDTH-1:0];
              carry_d        = sub_full[WIDTH];
            end
            OP_AND: z_d[WIDTH-1:0] = a & b;
            OP_OR:  z_d[WIDTH-1:0] = a | b;
            OP_NEG: z_d[WIDTH-1:0] = WIDTH'(-b);
            OP_PSB: z_d[WIDTH-1:0] = b;
            OP_NOT: z_d[WIDTH-1:0] = ~b;
            OP_SHL: z_d[WIDTH-1:0] = shl_res;
            OP_SHR: z_d[WIDTH-1:0] = shr_res;
            OP_SRA: z_d[WIDTH-1:0] = sra_res;
            OP_ROL: z_d[WIDTH-1:0] = rol_dbl[W2-1:WIDTH];
            OP_ROR: z_d[WIDTH-1:0] = ror_dbl[WIDTH-1:0];
            OP_MUL: begin
              done_d    = 1'b0;
              carry_d   = carry;
              dbz_d     = div_by_zero;
              opnd_d    = mag_a;
              work_d    = {(WIDTH+1)'(0), mag_b};
              is_div_d  = 1'b0;
              neg_res_d = a[WIDTH-1] ^ b[WIDTH-1];
              sign_a_d  = a[WIDTH-1];
              cnt_d     = CW'(WIDTH);
              state_d   = S_ITER;
            end
            OP_DIV: begin
              if (b == '0) begin
                // No iteration: z unchanged, flag the error
                dbz_d = 1'b1;
              end else begin
                done_d    = 1'b0;
                carry_d   = carry;
                dbz_d     = div_by_zero;
                opnd_d    = mag_b;
                work_d    = {(WIDTH+1)'(0), mag_a};
                is_div_d  = 1'b1;
                neg_res_d = a[WIDTH-1] ^ b[WIDTH-1];
                sign_a_d  = a[WIDTH-1];
                cnt_d     = CW'(WIDTH);
                state_d   = S_ITER;
              end
            end
            default: ;
          endcase
        end
      end

      S_ITER: begin
        work_d = is_div ? div_next : mul_next;
        cnt_d  = cnt - CW'(1);
        if (cnt == CW'(1)) state_d = S_FIX;
      end

      S_FIX: begin
        z_d     = is_div ? {rem_res, quo_res} : mul_res;
        carry_d = 1'b0;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state       <= S_IDLE;
      cnt         <= '0;
      work        <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      sign_a      <= 1'b0;
      z           <= '0;
      carry       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      work        <= work_d;
      opnd        <= opnd_d;
      is_div      <= is_div_d;
      neg_res     <= neg_res_d;
      sign_a      <= sign_a_d;
      z           <= z_d;
      carry       <= carry_d;
      busy        <= busy_d;
      done        <= done_d;
      div_by_zero <= dbz_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=32 and WIDTH=8.
module tb_seq_alu;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SRA = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_NEG = 4'b1000;
  localparam logic [3:0] OP_PSB = 4'b1001;
  localparam logic [3:0] OP_NOT = 4'b1010;
  localparam logic [3:0] OP_SHL = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;
  localparam logic [3:0] OP_ROL = 4'b1110;
  localparam logic [3:0] OP_ROR = 4'b1111;

  logic clk = 1'b0;
  logic clear;

  logic        start32;
  logic [3:0]  op32;
  logic [31:0] a32, b32;
  logic [63:0] z32;
  logic        carry32, busy32, done32, dbz32;

  logic        start8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] z8;
  logic        carry8, busy8, done8, dbz8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .clear(clear), .start(start32), .op(op32), .a(a32), .b(b32),
    .z(z32), .carry(carry32), .busy(busy32), .done(done32), .div_by_zero(dbz32)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .clear(clear), .start(start8), .op(op8), .a(a8), .b(b8),
    .z(z8), .carry(carry8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  // Issue one op on the 32-bit DUT and wait (bounded) for done.
  // lat = edges after the accept edge until done is seen (-1 on timeout).
  task automatic run32(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       output int lat, output int bcnt);
    int k;
    @(negedge clk);
    op32 = o; a32 = aa; b32 = bb; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    k = 1;
    bcnt = (busy32 === 1'b1) ? 1 : 0;
    while (done32 !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
      if (busy32 === 1'b1) bcnt++;
    end
    lat = (done32 === 1'b1) ? k - 1 : -1;
  endtask

  task automatic run8(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb,
                      output int lat);
    int k;
    @(negedge clk);
    op8 = o; a8 = aa; b8 = bb; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k = 1;
    while (done8 !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    lat = (done8 === 1'b1) ? k - 1 : -1;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({z32, carry32, busy32, done32, dbz32} !== 68'h0) begin
      errors++;
      $display("FAIL reset32: got z=%h c=%b busy=%b done=%b dbz=%b, want all 0",
               z32, carry32, busy32, done32, dbz32);
    end
    checks++;
    if ({z8, carry8, busy8, done8, dbz8} !== 20'h0) begin
      errors++;
      $display("FAIL reset8: got z=%h c=%b busy=%b done=%b dbz=%b, want all 0",
               z8, carry8, busy8, done8, dbz8);
    end
    clear = 1'b0;
  endtask

  task automatic test_mul();
    int lat, bc;
    run32(OP_MUL, 32'h8000_0000, 32'h8000_0000, lat, bc);
    checks++;
    if (z32 !== 64'h4000_0000_0000_0000) begin
      errors++; $display("FAIL mul_min_sq: z=%h want 4000000000000000", z32);
    end
    run32(OP_MUL, 32'hFFFF_FFFD, 32'd7, lat, bc);
    checks++;
    if (z32 !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++; $display("FAIL mul_neg3x7: z=%h want ffffffffffffffeb", z32);
    end
    checks++;
    if (lat != 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", lat); end
    checks++;
    if (bc != 33) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 33", bc); end
    checks++;
    if (carry32 !== 1'b0 || busy32 !== 1'b0) begin
      errors++; $display("FAIL mul_flags: carry=%b busy=%b want 0 0", carry32, busy32);
    end
  endtask

  task automatic test_add_sub();
    int lat, bc;
    run32(OP_ADD, 32'hFFFF_FFFF, 32'd1, lat, bc);
    checks++;
    if (z32 !== 64'hFFFF_FFFF_0000_0000 || carry32 !== 1'b1) begin
      errors++; $display("FAIL add_wrap: z=%h c=%b want ffffffff00000000 1", z32, carry32);
    end
    checks++;
    if (lat != 0 || bc != 0) begin
      errors++; $display("FAIL add_timing: lat=%0d busy=%0d want 0 0", lat, bc);
    end
    @(negedge clk);
    checks++;
    if (done32 !== 1'b0) begin errors++; $display("FAIL add_done_pulse: done=%b want 0", done32); end
    run32(OP_SUB, 32'd5, 32'd7, lat, bc);
    checks++;
    if (z32 !== 64'hFFFF_FFFF_FFFF_FFFE || carry32 !== 1'b0) begin
      errors++; $display("FAIL sub_borrow: z=%h c=%b want fffffffffffffffe 0", z32, carry32);
    end
  endtask

  task automatic test_div();
    int lat, bc;
    run32(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc);
    checks++;
    if (z32 !== 64'hFFFF_FFFF_FFFF_FFFD || lat != 33) begin
      errors++; $display("FAIL div_neg7_2: z=%h lat=%0d want fffffffffffffffd 33", z32, lat);
    end
    run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    checks++;
    if (z32 !== 64'h0000_0000_8000_0000 || dbz32 !== 1'b0) begin
      errors++; $display("FAIL div_min_m1: z=%h dbz=%b want 0000000080000000 0", z32, dbz32);
    end
    run32(OP_DIV, 32'd9, 32'd0, lat, bc);
    checks++;
    if (z32 !== 64'h0000_0000_8000_0000 || dbz32 !== 1'b1) begin
      errors++; $display("FAIL div_zero: z=%h dbz=%b want 0000000080000000 1", z32, dbz32);
    end
    checks++;
    if (lat != 0 || bc != 0) begin
      errors++; $display("FAIL div_zero_timing: lat=%0d busy=%0d want 0 0", lat, bc);
    end
  endtask

  task automatic test_shift_logic();
    logic [3:0]  ops  [12] = '{OP_SRA, OP_SHR, OP_SRA, OP_ROL, OP_SHL, OP_AND,
                               OP_OR,  OP_NEG, OP_PSB, OP_NOT, OP_ROR, OP_NOP};
    logic [31:0] as   [12] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001,
                               32'h8000_0001, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0,
                               32'h0, 32'h0, 32'h8000_0001, 32'h1234_5678};
    logic [31:0] bs   [12] = '{32'd4, 32'd32, 32'd40, 32'd33, 32'd1, 32'h0000_FF00,
                               32'h0000_FF00, 32'd1, 32'h1234_5678, 32'h0, 32'd1, 32'h9};
    logic [31:0] want [12] = '{32'hF800_0000, 32'h0, 32'hFFFF_FFFF, 32'h0000_0003,
                               32'h0000_0002, 32'h0000_F000, 32'h0000_FFF0, 32'hFFFF_FFFF,
                               32'h1234_5678, 32'hFFFF_FFFF, 32'hC000_0000, 32'hC000_0000};
    int lat, bc;
    for (int i = 0; i < 12; i++) begin
      run32(ops[i], as[i], bs[i], lat, bc);
      checks++;
      if (z32 !== {32'h0, want[i]} || carry32 !== 1'b0 || dbz32 !== 1'b0 || lat != 0) begin
        errors++;
        $display("FAIL shift_logic[%0d] op=%b: z=%h c=%b dbz=%b lat=%0d want %h 0 0 0",
                 i, ops[i], z32, carry32, dbz32, lat, {32'h0, want[i]});
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    op32 = OP_ADD; a32 = 32'd1; b32 = 32'd1; start32 = 1'b1;
    @(negedge clk);
    checks++;
    if (done32 !== 1'b1 || z32 !== 64'h2) begin
      errors++; $display("FAIL b2b_first: done=%b z=%h want 1 2", done32, z32);
    end
    op32 = OP_SUB; a32 = 32'd10; b32 = 32'd3;
    @(negedge clk);
    start32 = 1'b0;
    checks++;
    if (done32 !== 1'b1 || z32 !== 64'h7 || carry32 !== 1'b1) begin
      errors++; $display("FAIL b2b_second: done=%b z=%h c=%b want 1 7 1", done32, z32, carry32);
    end
    @(negedge clk);
    checks++;
    if (done32 !== 1'b0) begin errors++; $display("FAIL b2b_end: done=%b want 0", done32); end
  endtask

  task automatic test_busy_ignore();
    int k;
    @(negedge clk);
    op32 = OP_MUL; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    k = 1;
    while (done32 !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 5) begin op32 = OP_ADD; a32 = 32'd1; b32 = 32'd1; start32 = 1'b1; end
      if (k == 6) start32 = 1'b0;
      if (k == 10) begin
        checks++;
        if (z32 !== 64'h7 || busy32 !== 1'b1) begin
          errors++; $display("FAIL busy_hold: z=%h busy=%b want 7 1", z32, busy32);
        end
      end
    end
    checks++;
    if (z32 !== 64'hF || k - 1 != 33) begin
      errors++; $display("FAIL busy_ignore: z=%h lat=%0d want f 33", z32, k - 1);
    end
    @(negedge clk);
    checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b0 || z32 !== 64'hF) begin
      errors++; $display("FAIL busy_not_queued: busy=%b done=%b z=%h want 0 0 f",
                         busy32, done32, z32);
    end
  endtask

  task automatic test_clear_mid();
    int lat, bc, pulses;
    run32(OP_DIV, 32'd1, 32'd0, lat, bc);
    @(negedge clk);
    op32 = OP_DIV; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (busy32 !== 1'b1 || dbz32 !== 1'b1 || z32 !== 64'hF) begin
      errors++; $display("FAIL clear_pre: busy=%b dbz=%b z=%h want 1 1 f", busy32, dbz32, z32);
    end
    clear = 1'b1;
    #1;
    checks++;
    if ({z32, carry32, busy32, done32, dbz32} !== 68'h0) begin
      errors++; $display("FAIL clear_async: z=%h c=%b busy=%b done=%b dbz=%b want all 0",
                         z32, carry32, busy32, done32, dbz32);
    end
    @(negedge clk);
    clear = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32 === 1'b1 || busy32 === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL clear_no_done: activity=%0d want 0", pulses); end
    run32(OP_ADD, 32'd2, 32'd3, lat, bc);
    checks++;
    if (z32 !== 64'h5 || lat != 0) begin
      errors++; $display("FAIL clear_then_add: z=%h lat=%0d want 5 0", z32, lat);
    end
  endtask

  task automatic test_width8();
    int lat;
    run8(OP_MUL, 8'h80, 8'hFF, lat);
    checks++;
    if (z8 !== 16'h0080 || lat != 9) begin
      errors++; $display("FAIL w8_mul: z=%h lat=%0d want 0080 9", z8, lat);
    end
    run8(OP_DIV, 8'd100, 8'hF9, lat);
    checks++;
    if (z8 !== 16'h02F2 || lat != 9) begin
      errors++; $display("FAIL w8_div: z=%h lat=%0d want 02f2 9", z8, lat);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_add_sub();
    test_div();
    test_shift_logic();
    test_back_to_back();
    test_busy_ignore();
    test_clear_mid();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
